// File: rtl/palette_lut_if.sv
// Pixel lookup and palette write bus between the pixel generator and palette_lut.
// frame_tick / wr_blink exist only when PALETTE_BLINK_EN is defined.
interface palette_lut_if #(
  parameter int IDX_W   = 5,
  parameter int COLOR_W = 16
) ();
  logic               pix_valid_in;
  logic [IDX_W-1:0]   pix_idx;
  logic               pix_valid_out;
  logic [COLOR_W-1:0] pix_color;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [COLOR_W-1:0] wr_color;
  logic               wr_ready;
  logic               init_done;
`ifdef PALETTE_BLINK_EN
  logic               frame_tick;
  logic               wr_blink;
`endif

  modport master (
    output pix_valid_in, pix_idx, wr_en, wr_idx, wr_color,
`ifdef PALETTE_BLINK_EN
    output frame_tick, wr_blink,
`endif
    input  pix_valid_out, pix_color, wr_ready, init_done
  );

  modport slave (
    input  pix_valid_in, pix_idx, wr_en, wr_idx, wr_color,
`ifdef PALETTE_BLINK_EN
    input  frame_tick, wr_blink,
`endif
    output pix_valid_out, pix_color, wr_ready, init_done
  );
endinterface

// File: rtl/palette_lut.sv
// Programmable colour palette: self-loads a default table after reset, then serves
// 2-stage pipelined lookups and run-time writes. Optional blink feature: PALETTE_BLINK_EN.
module palette_lut #(
  parameter int IDX_W   = 5,
  parameter int COLOR_W = 16
`ifdef PALETTE_BLINK_EN
  , parameter int BLINK_W = 6
`endif
) (
  input logic          clk,
  input logic          reset,
  palette_lut_if.slave bus
);
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  // Index DEPTH-1 is always white, even if it collides with a named colour.
  function automatic logic [COLOR_W-1:0] default_color(input int i);
    logic [15:0] c;
    if (i == DEPTH - 1) begin
      c = 16'hFFFF;
    end else begin
      case (i)
        1:       c = 16'hF800;
        2:       c = 16'h07E0;
        3:       c = 16'h001F;
        4:       c = 16'h000F;
        5:       c = 16'h03E0;
        6:       c = 16'h03EF;
        7:       c = 16'h7800;
        8:       c = 16'h780F;
        9:       c = 16'h7BE0;
        10:      c = 16'hC618;
        11:      c = 16'h7BEF;
        12:      c = 16'h07FF;
        13:      c = 16'hF81F;
        14:      c = 16'hFFE0;
        15:      c = 16'hFD20;
        16:      c = 16'hF81F;
        17:      c = 16'hAFE5;
        default: c = 16'h0000;
      endcase
    end
    return COLOR_W'(c);
  endfunction

  state_e             state_q;
  logic [IDX_W-1:0]   cnt_q;
  logic               init_done_q;
  logic               wr_ready_q;

  logic [COLOR_W-1:0] mem_q [DEPTH];
  logic [COLOR_W-1:0] rd_color_q;
  logic               s1_valid_q;
  logic               pix_valid_q;
  logic [COLOR_W-1:0] pix_color_q;
  logic [COLOR_W-1:0] color_d;

  logic               we_d;
  logic [IDX_W-1:0]   waddr_d;
  logic [COLOR_W-1:0] wdata_d;

`ifdef PALETTE_BLINK_EN
  logic               blink_q [DEPTH];
  logic               rd_blink_q;
  logic               wblink_d;
  logic [BLINK_W-1:0] blink_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      wr_ready_q  <= 1'b0;
    end else if (state_q == ST_INIT) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == {IDX_W{1'b1}}) begin
        state_q     <= ST_RUN;
        init_done_q <= 1'b1;
        wr_ready_q  <= 1'b1;
      end
    end
  end

  // Single write port shared by the init sequencer and the run-time write bus.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = cnt_q;
    wdata_d = default_color(int'(cnt_q));
`ifdef PALETTE_BLINK_EN
    wblink_d = 1'b0;
`endif
    if (!reset) begin
      if (state_q == ST_INIT) begin
        we_d = 1'b1;
      end else if (bus.wr_en && wr_ready_q) begin
        we_d    = 1'b1;
        waddr_d = bus.wr_idx;
        wdata_d = bus.wr_color;
`ifdef PALETTE_BLINK_EN
        wblink_d = bus.wr_blink;
`endif
      end
    end
  end

  // Read and write share an edge, so a colliding lookup sees the old entry.
  always_ff @(posedge clk) begin
    if (we_d) begin
      mem_q[waddr_d] <= wdata_d;
    end
    rd_color_q <= mem_q[bus.pix_idx];
`ifdef PALETTE_BLINK_EN
    if (we_d) begin
      blink_q[waddr_d] <= wblink_d;
    end
    rd_blink_q <= blink_q[bus.pix_idx];
`endif
  end

`ifdef PALETTE_BLINK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
    end else if (bus.frame_tick) begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign color_d = (blink_cnt_q[BLINK_W-1] && rd_blink_q) ? '0 : rd_color_q;
`else
  assign color_d = rd_color_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_color_q <= '0;
    end else begin
      s1_valid_q  <= bus.pix_valid_in && init_done_q;
      pix_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        pix_color_q <= color_d;
      end
    end
  end

  assign bus.pix_valid_out = pix_valid_q;
  assign bus.pix_color     = pix_color_q;
  assign bus.wr_ready      = wr_ready_q;
  assign bus.init_done     = init_done_q;
endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: init timing, streaming lookups, writes, collisions,
// reset during RUN, writes ignored during INIT, and blink when PALETTE_BLINK_EN is defined.
module tb_palette_lut;
  localparam int IDX_W   = 5;
  localparam int COLOR_W = 16;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  palette_lut_if #(.IDX_W(IDX_W), .COLOR_W(COLOR_W)) bus ();

`ifdef PALETTE_BLINK_EN
  palette_lut #(.IDX_W(IDX_W), .COLOR_W(COLOR_W), .BLINK_W(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`else
  palette_lut #(.IDX_W(IDX_W), .COLOR_W(COLOR_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Isolated lookup: drive one index, observe the result two edges later.
  task automatic lookup(input string tag, input logic [IDX_W-1:0] idx, input logic [15:0] exp);
    bus.pix_valid_in = 1'b1;
    bus.pix_idx      = idx;
    step();
    bus.pix_valid_in = 1'b0;
    step();
    check({tag, "_valid"}, 32'(bus.pix_valid_out), 32'd1);
    check(tag, 32'(bus.pix_color), 32'(exp));
  endtask

  logic [IDX_W-1:0] stream_idx [6] = '{5'd0, 5'd1, 5'd2, 5'd17, 5'd31, 5'd20};
  logic [15:0]      stream_exp [6] = '{16'h0000, 16'hF800, 16'h07E0, 16'hAFE5, 16'hFFFF, 16'h0000};

  initial begin
    reset            = 1'b1;
    bus.pix_valid_in = 1'b0;
    bus.pix_idx      = '0;
    bus.wr_en        = 1'b0;
    bus.wr_idx       = '0;
    bus.wr_color     = '0;
`ifdef PALETTE_BLINK_EN
    bus.frame_tick   = 1'b0;
    bus.wr_blink     = 1'b0;
`endif

    step();
    check("rst_init_done", 32'(bus.init_done), 32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_valid", 32'(bus.pix_valid_out), 32'd0);
    check("rst_color", 32'(bus.pix_color), 32'd0);

    // Release reset; hold a write to idx 5 and a lookup throughout INIT.
    reset            = 1'b0;
    bus.wr_en        = 1'b1;
    bus.wr_idx       = 5'd5;
    bus.wr_color     = 16'hABCD;
    bus.pix_valid_in = 1'b1;
    bus.pix_idx      = 5'd1;
    for (int i = 1; i <= 32; i++) begin
      step();
      check($sformatf("init_done_c%0d", i + 1), 32'(bus.init_done), 32'(i == 32));
      check($sformatf("wr_ready_c%0d", i + 1), 32'(bus.wr_ready), 32'(i == 32));
      check($sformatf("init_valid_c%0d", i + 1), 32'(bus.pix_valid_out), 32'd0);
    end
    bus.wr_en        = 1'b0;
    bus.pix_valid_in = 1'b0;

    // Back-to-back stream.
    for (int k = 0; k <= 7; k++) begin
      bus.pix_valid_in = (k < 6);
      bus.pix_idx      = (k < 6) ? stream_idx[k] : '0;
      step();
      if (k >= 1 && k <= 6) begin
        check($sformatf("stream%0d_valid", k - 1), 32'(bus.pix_valid_out), 32'd1);
        check($sformatf("stream%0d_color", k - 1), 32'(bus.pix_color), 32'(stream_exp[k - 1]));
      end
    end
    check("stream_end_valid", 32'(bus.pix_valid_out), 32'd0);

    lookup("init_write_ignored", 5'd5, 16'h03E0);

    // Run-time write then lookup.
    bus.wr_en    = 1'b1;
    bus.wr_idx   = 5'd3;
    bus.wr_color = 16'h1234;
    step();
    bus.wr_en = 1'b0;
    lookup("write3", 5'd3, 16'h1234);

    // Same-edge write and lookup of idx 3: old value, then new value.
    bus.wr_en        = 1'b1;
    bus.wr_color     = 16'h5678;
    bus.pix_valid_in = 1'b1;
    bus.pix_idx      = 5'd3;
    step();
    bus.wr_en = 1'b0;
    step();
    check("collide_old", 32'(bus.pix_color), 32'h1234);
    bus.pix_valid_in = 1'b0;
    step();
    check("collide_new_valid", 32'(bus.pix_valid_out), 32'd1);
    check("collide_new", 32'(bus.pix_color), 32'h5678);

    // Reset with the pipeline full.
    bus.pix_valid_in = 1'b1;
    bus.pix_idx      = 5'd1;
    step();
    step();
    check("pre_reset_valid", 32'(bus.pix_valid_out), 32'd1);
    reset = 1'b1;
    step();
    check("midrst_valid", 32'(bus.pix_valid_out), 32'd0);
    check("midrst_init_done", 32'(bus.init_done), 32'd0);
    check("midrst_color", 32'(bus.pix_color), 32'd0);
    reset            = 1'b0;
    bus.pix_valid_in = 1'b0;
    for (int i = 0; i < 40 && bus.init_done !== 1'b1; i++) step();
    check("reinit_done", 32'(bus.init_done), 32'd1);
    lookup("reinit_idx3", 5'd3, 16'h001F);
    lookup("reinit_idx31", 5'd31, 16'hFFFF);

`ifdef PALETTE_BLINK_EN
    bus.wr_en    = 1'b1;
    bus.wr_idx   = 5'd1;
    bus.wr_color = 16'hF800;
    bus.wr_blink = 1'b1;
    step();
    bus.wr_en    = 1'b0;
    bus.wr_blink = 1'b0;
    for (int t = 0; t <= 4; t++) begin
      lookup($sformatf("blink_idx1_t%0d", t), 5'd1, (t == 2 || t == 3) ? 16'h0000 : 16'hF800);
      lookup($sformatf("blink_idx2_t%0d", t), 5'd2, 16'h07E0);
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
